// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: two-entry elastic pipeline register (skid buffer) with a
// valid/ready handshake on both sides, registered ready_o and synchronous flush.
// Optional build macro SKID_PERF_CNT_EN adds a saturating stall counter on
// stall_cnt_o.
module skid_pipe_reg #(
   parameter int unsigned Size = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [Size-1:0] data_i,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [Size-1:0] data_o,
   output logic            valid_o,
`ifdef SKID_PERF_CNT_EN
   output logic [31:0]     stall_cnt_o,
`endif
   input  logic            ready_i
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [Size-1:0] main_q;
   logic [Size-1:0] main_d;
   logic [Size-1:0] skid_q;
   logic [Size-1:0] skid_d;
   logic            valid_q;
   logic            ready_q;
   logic            accept;

   // ready_q is only ever written from the next-state, so ready_i never
   // reaches ready_o combinationally.
   assign accept  = valid_i && ready_q;
   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign data_o  = main_q;

   // Next-state and data-path select by occupancy; flush overrides the state.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = data_i;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (accept && ready_i) begin
               main_d = data_i;
            end else if (accept && !ready_i) begin
               skid_d  = data_i;
               state_d = ST_FULL;
            end else if (!accept && ready_i) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (ready_i) begin
               main_d  = skid_q;
               state_d = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   // State, data registers and registered handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         valid_q <= (state_d != ST_EMPTY);
         ready_q <= (state_d != ST_FULL);
      end
   end

`ifdef SKID_PERF_CNT_EN
   logic [31:0] stall_cnt_q;

   assign stall_cnt_o = stall_cnt_q;

   // Count edges where the output is held by downstream; saturate, survive flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (valid_q && !ready_i && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// tb_skid_pipe_reg: scoreboard bench for skid_pipe_reg; expected data is queued
// on upstream acceptance and popped by an independent output monitor.
module tb_skid_pipe_reg;

   localparam int unsigned Size = 64;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic [Size-1:0] data_i;
   logic            valid_i;
   logic            ready_o;
   logic [Size-1:0] data_o;
   logic            valid_o;
   logic            ready_i;
`ifdef SKID_PERF_CNT_EN
   logic [31:0]     stall_cnt_o;
`endif

   int total;
   int bad;
   logic [Size-1:0] sb[$];

   skid_pipe_reg #(.Size(Size)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_o     (data_o),
      .valid_o    (valid_o),
`ifdef SKID_PERF_CNT_EN
      .stall_cnt_o(stall_cnt_o),
`endif
      .ready_i    (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Output monitor: every downstream transfer must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %h expected none", data_o);
         end else begin
            check("scoreboard_data", data_o, sb.pop_front());
         end
      end
   end

   // One clock: at the negedge record acceptance/flush, then step past posedge.
   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         if (flush) sb.delete();
         else if (valid_i && ready_o) sb.push_back(data_i);
      end
      @(posedge clk);
      #1;
   endtask

   // Offer one datum and hold it until accepted, bounded.
   task automatic send(input logic [63:0] d);
      int unsigned n;
      valid_i = 1'b1;
      data_i  = d;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (ready_o) begin
            sb.push_back(d);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) check("send_timeout", 64'(n), 64'd0);
      valid_i = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b1;
      flush   = 1'b0;
      valid_i = 1'b1;
      data_i  = 64'hDEAD_BEEF_0000_0001;
      ready_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_valid_o", 64'(valid_o), 64'd0);
      check("reset_ready_o", 64'(ready_o), 64'd1);
      check("reset_data_o", data_o, 64'd0);
      @(posedge clk);
      #1;
      check("reset_hold_valid_o", 64'(valid_o), 64'd0);
      valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pass-through, one per cycle, 1-cycle latency.
      ready_i = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         valid_i = 1'b1;
         data_i  = 64'(i);
         @(negedge clk);
         check("pass_ready_o", 64'(ready_o), 64'd1);
         if (i > 1) check("pass_latency", data_o, 64'(i - 1));
         step_tail();
      end
      valid_i = 1'b0;
      step();
      check("pass_last", data_o, 64'h10);
      step();
      check("pass_drained_valid", 64'(valid_o), 64'd0);

      // Backpressure: 0xA, 0xB accepted, 0xC held upstream.
      ready_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 64'hA;
      step();
      check("bp_ready_after_1", 64'(ready_o), 64'd1);
      data_i = 64'hB;
      step();
      check("bp_ready_after_2", 64'(ready_o), 64'd0);
      data_i = 64'hC;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stable_data_o", data_o, 64'hA);
         check("stable_valid_o", 64'(valid_o), 64'd1);
         check("stable_ready_o", 64'(ready_o), 64'd0);
      end
      ready_i = 1'b1;
      send(64'hC);
      step();
      step();
      check("bp_drained_valid", 64'(valid_o), 64'd0);
      check("bp_queue_empty", 64'(sb.size()), 64'd0);

      // Flush from FULL, with a reset first so the stall count starts at 0.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_valid", 64'(valid_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      ready_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 64'h1A;
      step();
      data_i = 64'h1B;
      step();
      valid_i = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("flush_pre_ready", 64'(ready_o), 64'd0);
      flush   = 1'b1;
      valid_i = 1'b1;
      data_i  = 64'h55;
      step();
      flush   = 1'b0;
      valid_i = 1'b0;
      check("flush_valid_o", 64'(valid_o), 64'd0);
      check("flush_ready_o", 64'(ready_o), 64'd1);
`ifdef SKID_PERF_CNT_EN
      check("stall_cnt_after_flush", 64'(stall_cnt_o), 64'd7);
`endif
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("flush_no_output", 64'(valid_o), 64'd0);
`ifdef SKID_PERF_CNT_EN
      check("stall_cnt_stays", 64'(stall_cnt_o), 64'd7);

      // Saturation: preload just below the top, then stall several edges.
      ready_i = 1'b0;
      send(64'h2A);
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.stall_cnt_q;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step();
      check("stall_cnt_saturate", 64'(stall_cnt_o), 64'hFFFF_FFFF);
      ready_i = 1'b1;
      step();
      step();
`endif
      check("final_queue_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Remainder of a step when the caller already waited on the negedge.
   task automatic step_tail();
      if (rst_n) begin
         if (flush) sb.delete();
         else if (valid_i && ready_o) sb.push_back(data_i);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
